// File: rtl/clk_div_prog.sv
// Programmable clock-enable / clock-divider with wrap-aligned divisor reload.
// Optional PWM duty control in pulse mode is enabled by defining CLK_DIV_DUTY_EN.
module clk_div_prog #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 25000000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
`ifdef CLK_DIV_DUTY_EN
    input  logic [WIDTH-1:0] duty_in,
`endif
    output logic             clkout,
    output logic             tick,
    output logic             pending
);

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam logic [WIDTH-1:0] L_DIV_RST = WIDTH'(DEFAULT_DIV);
`ifdef CLK_DIV_DUTY_EN
    localparam logic [WIDTH-1:0] L_DUTY_RST = WIDTH'((DEFAULT_DIV + 1) / 2);
`endif

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_act;
    logic [WIDTH-1:0] r_div_sh;
    logic             r_pending;
    logic             r_tick;
    logic             r_clkout;
`ifdef CLK_DIV_DUTY_EN
    logic [WIDTH-1:0] r_duty_act;
    logic [WIDTH-1:0] r_duty_sh;
`endif

    mode_e w_mode;
    logic  w_wrap;
    logic  w_clkout_nxt;

    assign w_mode = mode_e'(mode);
    assign w_wrap = en & (r_cnt == r_div_act);

    // Pulse mode follows the tick strobe (or PWM compare); toggle mode flips only on a wrap.
    always_comb begin
        w_clkout_nxt = r_clkout;
        if (en) begin
            if (w_mode == MODE_TOGGLE) begin
                if (w_wrap) begin
                    w_clkout_nxt = ~r_clkout;
                end
            end else begin
`ifdef CLK_DIV_DUTY_EN
                w_clkout_nxt = (r_cnt < r_duty_act);
`else
                w_clkout_nxt = w_wrap;
`endif
            end
        end else begin
`ifndef CLK_DIV_DUTY_EN
            if (w_mode == MODE_PULSE) begin
                w_clkout_nxt = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt      <= '0;
            r_div_act  <= L_DIV_RST;
            r_div_sh   <= L_DIV_RST;
            r_pending  <= 1'b0;
            r_tick     <= 1'b0;
            r_clkout   <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
            r_duty_act <= L_DUTY_RST;
            r_duty_sh  <= L_DUTY_RST;
`endif
        end else begin
            r_tick   <= w_wrap;
            r_clkout <= w_clkout_nxt;
            if (!en) begin
                // Idle reload: no period is running, so apply immediately and restart.
                if (div_load) begin
                    r_div_act  <= div_in;
                    r_div_sh   <= div_in;
                    r_cnt      <= '0;
                    r_pending  <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
                    r_duty_act <= duty_in;
                    r_duty_sh  <= duty_in;
`endif
                end
            end else if (w_wrap) begin
                r_cnt     <= '0;
                r_pending <= 1'b0;
                if (div_load) begin
                    r_div_act  <= div_in;
                    r_div_sh   <= div_in;
`ifdef CLK_DIV_DUTY_EN
                    r_duty_act <= duty_in;
                    r_duty_sh  <= duty_in;
`endif
                end else if (r_pending) begin
                    r_div_act  <= r_div_sh;
`ifdef CLK_DIV_DUTY_EN
                    r_duty_act <= r_duty_sh;
`endif
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (div_load) begin
                    r_div_sh   <= div_in;
                    r_pending  <= 1'b1;
`ifdef CLK_DIV_DUTY_EN
                    r_duty_sh  <= duty_in;
`endif
                end
            end
        end
    end

    assign clkout  = r_clkout;
    assign tick    = r_tick;
    assign pending = r_pending;

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable clock-enable and clock-divider generator, the parametrised successor of the fixed 25 MHz-count divider. It produces a one-cycle `tick` strobe every `div+1` cycles for enabling slow logic such as displays, debouncers and step timers. It also produces a `clkout` square wave or pulse train. The divisor is reloadable at run time with glitch-free, wrap-aligned update. It sits beside the board clock and feeds the display, LED and timer blocks.

## Interface
- `WIDTH`, 32: counter and divisor width in bits.
- `DEFAULT_DIV`, 25000000: terminal count loaded into the active and shadow divisors on reset. Must fit in `WIDTH`.

- `clk`, in, 1: system clock; all logic on the rising edge.
- `clr`, in, 1: reset, synchronous, active-high.
- `en`, in, 1: count enable.
- `mode`, in, 1: 0 = toggle (square wave), 1 = pulse.
- `div_in`, in, WIDTH: new terminal count.
- `div_load`, in, 1: one-cycle strobe that captures `div_in`.
- `clkout`, out, 1: divided output, registered.
- `tick`, out, 1: one-cycle strobe at each wrap, registered.
- `pending`, out, 1: a captured divisor is waiting for the next wrap.

## Operation
- **Internal registers:**
  - `cnt` (WIDTH)
  - `div_act` (WIDTH): the active terminal count
  - `div_sh` (WIDTH): the shadow terminal count
- **Reset** (`clr`=1 at an edge):
  - `cnt`=0, `div_act`=`div_sh`=`DEFAULT_DIV`
  - `clkout`=0, `tick`=0, `pending`=0
  - `clr` overrides every other input.
- **Counting:** while `en`=1, `cnt` increments each cycle. When `cnt==div_act` (a wrap):
  - `cnt`<=0
  - `tick`<=1 for the next cycle only
  - mode 0: `clkout` toggles
  - `div_act`<=`div_sh` if `pending`; `pending`<=0
- **Mode 1:** `clkout` equals `tick`.
- **Mode change:** takes effect at the next edge. Entering mode 0 starts toggling from the current `clkout` value.
- **Divisor load while `en`=1:**
  - `div_load` captures `div_in` into `div_sh` and sets `pending`=1.
  - `div_act` changes only at the next wrap, so no truncated or stretched period is ever produced.
  - A later load before the wrap overwrites `div_sh`; the last one wins.
- **Load in the same cycle as a wrap:** `div_in` goes straight to `div_act` at that wrap and `pending` stays 0.
- **Load while `en`=0:**
  - `div_act`, `div_sh` <= `div_in`
  - `cnt`<=0, `pending`<=0
  - `clkout` holds.
- **`en`=0:** `cnt` and `clkout` hold and `tick`=0. Counting resumes from the held `cnt`.
- **`div_act`=0:** every enabled cycle is a wrap.
  - `tick` stays high continuously.
  - mode 0: `clkout` toggles every cycle (clk/2).
- **Arithmetic:** unsigned; `cnt` never exceeds `div_act`, so it never overflows.

## Timing
- Outputs are registered; there is no combinational path from input to output.
- `tick` period = `div_act`+1 cycles.
- `clkout` period:
  - mode 0: 2·(`div_act`+1) cycles, 50% duty.
  - mode 1: `div_act`+1 cycles, high for 1 cycle.
- First `tick` after reset with `en`=1 held: `tick` is high in the cycle after the (`DEFAULT_DIV`+1)th enabled edge following `clr` release.
- `pending` rises the cycle after `div_load` and falls the cycle after the wrap that consumes it.
- Reset mid-operation drops all outputs to 0 at the next edge.

## Configuration
- **`CLK_DIV_DUTY_EN` defined:**
  - Adds an input port `duty_in` (WIDTH) and an internal `duty_act`/`duty_sh` register pair.
  - The pair is captured by the same `div_load` under the same shadow and wrap rules; reset value is (`DEFAULT_DIV`+1)/2.
  - In mode 1, `clkout` is registered `cnt < duty_act` (PWM).
  - `duty_act`=0 gives constant low; `duty_act`>`div_act` gives constant high.
  - `tick` and mode 0 behaviour are unchanged.
- **Macro undefined:** no `duty_in` port; mode 1 `clkout`=`tick`.

## Test plan
All scenarios use `WIDTH`=8, `DEFAULT_DIV`=3.
- Reset, `en`=1, `mode`=0 -> `tick` high 1 of every 4 cycles; `clkout` period 8 cycles; first `tick` in the cycle after the 4th enabled edge.
- `mode`=1 (macro off) -> `clkout` identical to `tick` every cycle.
- `div_load` with `div_in`=1 at `cnt`=1 -> `pending`=1 until the wrap; that period is still 4 cycles, then `tick` every 2 cycles. Load coincident with a wrap -> new period immediately, `pending` never set.
- `div_in`=0 loaded with `en`=0, then `en`=1 -> `tick` constantly high; `clkout` toggles every cycle.
- `en`=0 at `cnt`=2 for 5 cycles -> `cnt` and `clkout` frozen, `tick`=0; the next `tick` comes 2 cycles after `en` rises. `clr` mid-period -> all outputs 0, period back to 4.
- `CLK_DIV_DUTY_EN`, `mode`=1, `duty_in`=2, `div_in`=3 -> `clkout` high 2 of every 4 cycles; `duty_in`=0 -> constant low; `duty_in`=5 -> constant high.
